// File: rtl/fp_alu_mode_scheduler_if.sv
// Issue/result handshake bundle between the two requesters, the FP ALU and
// the mode scheduler. The master side drives requests and ALU result strobes;
// the slave side (the scheduler) drives the readies and the ALU controls.
interface fp_alu_mode_scheduler_if;
   logic dp_req_valid;
   logic dp_req_ready;
   logic vm_req_valid;
   logic vm_req_ready;
   logic alu_ready;
   logic alu_dot_product_mode;
   logic alu_dp_valid;
   logic alu_vm_valid;

   modport master (
      output dp_req_valid,
      output vm_req_valid,
      output alu_dp_valid,
      output alu_vm_valid,
      input  dp_req_ready,
      input  vm_req_ready,
      input  alu_ready,
      input  alu_dot_product_mode
   );

   modport slave (
      input  dp_req_valid,
      input  vm_req_valid,
      input  alu_dp_valid,
      input  alu_vm_valid,
      output dp_req_ready,
      output vm_req_ready,
      output alu_ready,
      output alu_dot_product_mode
   );
endinterface

// File: rtl/fp_alu_mode_scheduler.sv
// fp_alu_mode_scheduler: arbitrates a dot-product and a vector-multiply
// requester onto one FP ALU whose mode can only change once the pipeline is
// empty. Each requester gets bursts of up to MAX_BURST issues while the other
// waits; a mode switch drains all in-flight results first.
// Optional macro FP_ALU_SCHED_PERF_CNT_EN adds switch_count/stall_cycles.
module fp_alu_mode_scheduler #(
   parameter int MAX_BURST       = 16,
   parameter int MAX_OUTSTANDING = 32,
   parameter int CNT_WIDTH       = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   fp_alu_mode_scheduler_if.slave bus,
   output logic                  busy,
   output logic                  err_underflow
`ifdef FP_ALU_SCHED_PERF_CNT_EN
   ,
   output logic [31:0]           switch_count,
   output logic [31:0]           stall_cycles
`endif
);

   typedef enum logic [1:0] {IDLE, DP_RUN, VM_RUN, DRAIN} state_t;

   localparam logic [CNT_WIDTH-1:0] BURST_MAX = CNT_WIDTH'(MAX_BURST);
   localparam logic [CNT_WIDTH-1:0] OUT_MAX   = CNT_WIDTH'(MAX_OUTSTANDING);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

   state_t                 state, state_next;
   logic [CNT_WIDTH-1:0]   outstanding, outstanding_next;
   logic [CNT_WIDTH-1:0]   burst, burst_next;
   // mode doubles as the last-grant record: 1 = dot product was granted last
   logic                   mode, mode_next;
   logic                   err_next;
   logic                   dp_issue, vm_issue, issue;
   logic                   result_match, result_dec;
   logic                   own_valid, other_valid, enter_run;

   assign bus.dp_req_ready = (state == DP_RUN) && (outstanding < OUT_MAX) &&
                             ((burst < BURST_MAX) || !bus.vm_req_valid);
   assign bus.vm_req_ready = (state == VM_RUN) && (outstanding < OUT_MAX) &&
                             ((burst < BURST_MAX) || !bus.dp_req_valid);

   assign dp_issue                 = bus.dp_req_valid && bus.dp_req_ready;
   assign vm_issue                 = bus.vm_req_valid && bus.vm_req_ready;
   assign issue                    = dp_issue || vm_issue;
   assign bus.alu_ready            = issue;
   assign bus.alu_dot_product_mode = mode;

   assign own_valid    = mode ? bus.dp_req_valid : bus.vm_req_valid;
   assign other_valid  = mode ? bus.vm_req_valid : bus.dp_req_valid;
   assign result_match = mode ? bus.alu_dp_valid : bus.alu_vm_valid;
   assign result_dec   = result_match && (outstanding != '0);

   assign busy = (state != IDLE) || (outstanding != '0);

   // In-flight count and error flag: a strobe of the wrong mode or with nothing in flight is an ALU error
   always_comb begin
      outstanding_next = outstanding;
      if (issue && !result_dec) begin
         outstanding_next = outstanding + CNT_ONE;
      end else if (!issue && result_dec) begin
         outstanding_next = outstanding - CNT_ONE;
      end
      err_next = err_underflow ||
                 (bus.alu_dp_valid && (!mode || (outstanding == '0))) ||
                 (bus.alu_vm_valid && (mode || (outstanding == '0)));
   end

   // Next state and mode: grant, burst-limit drain, and switch once the pipe is empty
   always_comb begin
      state_next = state;
      mode_next  = mode;
      enter_run  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.dp_req_valid && bus.vm_req_valid) begin
               state_next = mode ? VM_RUN : DP_RUN;
               mode_next  = !mode;
               enter_run  = 1'b1;
            end else if (bus.dp_req_valid) begin
               state_next = DP_RUN;
               mode_next  = 1'b1;
               enter_run  = 1'b1;
            end else if (bus.vm_req_valid) begin
               state_next = VM_RUN;
               mode_next  = 1'b0;
               enter_run  = 1'b1;
            end
         end
         DP_RUN, VM_RUN: begin
            if (other_valid && (!own_valid || (burst == BURST_MAX))) begin
               state_next = DRAIN;
            end else if (!bus.dp_req_valid && !bus.vm_req_valid &&
                         (outstanding_next == '0)) begin
               state_next = IDLE;
            end
         end
         DRAIN: begin
            if (outstanding_next == '0) begin
               state_next = mode ? VM_RUN : DP_RUN;
               mode_next  = !mode;
               enter_run  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Burst length: restart per grant, and forgive a full burst when nobody else is waiting
   always_comb begin
      burst_next = burst;
      if (enter_run) begin
         burst_next = '0;
      end else if ((burst == BURST_MAX) && !other_valid) begin
         burst_next = issue ? CNT_ONE : '0;
      end else if (issue && (burst != BURST_MAX)) begin
         burst_next = burst + CNT_ONE;
      end
   end

   // State registers; reset abandons any in-flight accounting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         outstanding   <= '0;
         burst         <= '0;
         mode          <= 1'b0;
         err_underflow <= 1'b0;
      end else begin
         state         <= state_next;
         outstanding   <= outstanding_next;
         burst         <= burst_next;
         mode          <= mode_next;
         err_underflow <= err_next;
      end
   end

`ifdef FP_ALU_SCHED_PERF_CNT_EN
   // Performance counters: mode switches completed and cycles a requester waited
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         switch_count <= '0;
         stall_cycles <= '0;
      end else begin
         if ((state == DRAIN) && (state_next != DRAIN)) begin
            switch_count <= switch_count + 32'd1;
         end
         if ((bus.dp_req_valid && !bus.dp_req_ready) ||
             (bus.vm_req_valid && !bus.vm_req_ready)) begin
            stall_cycles <= stall_cycles + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fp_alu_mode_scheduler.sv
// Testbench for fp_alu_mode_scheduler. A transaction-level reference model
// (owner / draining flag / streak, with in-flight results held in a queue
// that also plays the ALU) predicts every output each cycle.
module tb_fp_alu_mode_scheduler;
   localparam int MB = 4;
   localparam int MO = 8;
   localparam int CW = 6;

   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   logic err_underflow;
`ifdef FP_ALU_SCHED_PERF_CNT_EN
   logic [31:0] switch_count;
   logic [31:0] stall_cycles;
`endif

   fp_alu_mode_scheduler_if sched_if ();

   fp_alu_mode_scheduler #(
      .MAX_BURST(MB),
      .MAX_OUTSTANDING(MO),
      .CNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(sched_if),
      .busy(busy),
      .err_underflow(err_underflow)
`ifdef FP_ALU_SCHED_PERF_CNT_EN
      ,
      .switch_count(switch_count),
      .stall_cycles(stall_cycles)
`endif
   );

   // Free-running clock
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc;
   int lat;
   int due_q[$];
   bit mode_q[$];
   int m_owner;     // 0 = nobody, 1 = dot product, 2 = vector multiply
   bit m_drain;
   bit m_mode;
   bit m_err;
   int m_streak;
   int m_switches;
   int m_stalls;
   int obs_issues;
   bit obs_mode_q[$];

   task automatic reset_model();
      m_owner    = 0;
      m_drain    = 1'b0;
      m_mode     = 1'b0;
      m_err      = 1'b0;
      m_streak   = 0;
      m_switches = 0;
      m_stalls   = 0;
      due_q.delete();
      mode_q.delete();
      obs_issues = 0;
      obs_mode_q.delete();
   endtask

   task automatic drive_idle();
      sched_if.dp_req_valid = 1'b0;
      sched_if.vm_req_valid = 1'b0;
      sched_if.alu_dp_valid = 1'b0;
      sched_if.alu_vm_valid = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive_idle();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      reset_model();
   endtask

   // One clock: drive inputs, compare DUT against the model, advance the model
   task automatic step_cycle(input bit dpv, input bit vmv, input bit sdp, input bit svm);
      bit real_strobe, rs_mode, e_dpr, e_vmr, e_alu, e_busy, dpi, vmi, own_v, other_v;
      int outs, new_out;
      @(negedge clk);
      real_strobe = (due_q.size() > 0) && (due_q[0] == cyc);
      rs_mode     = (due_q.size() > 0) ? mode_q[0] : 1'b0;
      sched_if.dp_req_valid = dpv;
      sched_if.vm_req_valid = vmv;
      sched_if.alu_dp_valid = (real_strobe && rs_mode) || sdp;
      sched_if.alu_vm_valid = (real_strobe && !rs_mode) || svm;
      #1;
      outs   = due_q.size();
      e_dpr  = (m_owner == 1) && !m_drain && (outs < MO) && ((m_streak < MB) || !vmv);
      e_vmr  = (m_owner == 2) && !m_drain && (outs < MO) && ((m_streak < MB) || !dpv);
      e_alu  = (dpv && e_dpr) || (vmv && e_vmr);
      e_busy = (m_owner != 0) || (outs != 0);

      n_cmp++;
      if (sched_if.dp_req_ready !== e_dpr) begin
         n_bad++;
         $display("[TB] FAIL dp_req_ready cycle %0d: got %b want %b", cyc, sched_if.dp_req_ready, e_dpr);
      end
      n_cmp++;
      if (sched_if.vm_req_ready !== e_vmr) begin
         n_bad++;
         $display("[TB] FAIL vm_req_ready cycle %0d: got %b want %b", cyc, sched_if.vm_req_ready, e_vmr);
      end
      n_cmp++;
      if (sched_if.alu_ready !== e_alu) begin
         n_bad++;
         $display("[TB] FAIL alu_ready cycle %0d: got %b want %b", cyc, sched_if.alu_ready, e_alu);
      end
      n_cmp++;
      if (sched_if.alu_dot_product_mode !== m_mode) begin
         n_bad++;
         $display("[TB] FAIL mode cycle %0d: got %b want %b", cyc, sched_if.alu_dot_product_mode, m_mode);
      end
      n_cmp++;
      if (busy !== e_busy) begin
         n_bad++;
         $display("[TB] FAIL busy cycle %0d: got %b want %b", cyc, busy, e_busy);
      end
      n_cmp++;
      if (err_underflow !== m_err) begin
         n_bad++;
         $display("[TB] FAIL err_underflow cycle %0d: got %b want %b", cyc, err_underflow, m_err);
      end
`ifdef FP_ALU_SCHED_PERF_CNT_EN
      n_cmp++;
      if (switch_count !== 32'(m_switches)) begin
         n_bad++;
         $display("[TB] FAIL switch_count cycle %0d: got %0d want %0d", cyc, switch_count, m_switches);
      end
      n_cmp++;
      if (stall_cycles !== 32'(m_stalls)) begin
         n_bad++;
         $display("[TB] FAIL stall_cycles cycle %0d: got %0d want %0d", cyc, stall_cycles, m_stalls);
      end
`endif
      if (sched_if.alu_ready === 1'b1) begin
         obs_issues++;
         obs_mode_q.push_back(sched_if.alu_dot_product_mode);
      end

      if (sdp && (!m_mode || outs == 0)) m_err = 1'b1;
      if (svm && (m_mode || outs == 0)) m_err = 1'b1;
      if ((dpv && !e_dpr) || (vmv && !e_vmr)) m_stalls++;
      if (real_strobe) begin
         void'(due_q.pop_front());
         void'(mode_q.pop_front());
      end
      dpi = dpv && e_dpr;
      vmi = vmv && e_vmr;
      if (dpi || vmi) begin
         due_q.push_back(cyc + lat);
         mode_q.push_back(dpi);
      end
      new_out = due_q.size();

      if (m_owner == 0) begin
         if (dpv || vmv) begin
            if (dpv && vmv) m_owner = m_mode ? 2 : 1;
            else            m_owner = dpv ? 1 : 2;
            m_mode   = (m_owner == 1);
            m_streak = 0;
         end
      end else if (m_drain) begin
         if (new_out == 0) begin
            m_owner    = (m_owner == 1) ? 2 : 1;
            m_mode     = (m_owner == 1);
            m_streak   = 0;
            m_drain    = 1'b0;
            m_switches++;
         end
      end else begin
         own_v   = (m_owner == 1) ? dpv : vmv;
         other_v = (m_owner == 1) ? vmv : dpv;
         if (other_v && (!own_v || m_streak == MB)) m_drain = 1'b1;
         else if (!dpv && !vmv && new_out == 0) m_owner = 0;
         if (m_streak == MB && !other_v) m_streak = (dpi || vmi) ? 1 : 0;
         else if ((dpi || vmi) && m_streak < MB) m_streak++;
      end
      cyc++;
   endtask

   // Let everything retire with no requests; a stuck pipeline is a failure
   task automatic drain_to_idle();
      int budget;
      budget = 0;
      while ((m_owner != 0 || due_q.size() != 0) && budget < 100) begin
         step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
         budget++;
      end
      step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL drain_timeout: busy got %b want 0", busy);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0;
      sched_if.dp_req_valid = 1'b1;
      sched_if.vm_req_valid = 1'b1;
      sched_if.alu_dp_valid = 1'b0;
      sched_if.alu_vm_valid = 1'b0;
      #1;
      n_cmp++;
      if ({sched_if.dp_req_ready, sched_if.vm_req_ready, sched_if.alu_ready} !== 3'b000) begin
         n_bad++;
         $display("[TB] FAIL reset_readies: got %b%b%b want 000", sched_if.dp_req_ready,
                  sched_if.vm_req_ready, sched_if.alu_ready);
      end
      n_cmp++;
      if ({busy, err_underflow, sched_if.alu_dot_product_mode} !== 3'b000) begin
         n_bad++;
         $display("[TB] FAIL reset_status: got busy=%b err=%b mode=%b want 000", busy,
                  err_underflow, sched_if.alu_dot_product_mode);
      end
      apply_reset();
   endtask

   task automatic test_single_requester();
      lat = 6;
      for (int i = 0; i < 41; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_issues !== 40) begin
         n_bad++;
         $display("[TB] FAIL single_issue_count: got %0d want 40", obs_issues);
      end
      drain_to_idle();
   endtask

   task automatic test_contention();
      apply_reset();
      lat = 5;
      for (int i = 0; i < 40; i++) step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (obs_mode_q.size() < 2 * MB) begin
         n_bad++;
         $display("[TB] FAIL contention_issue_count: got %0d want >= %0d", obs_mode_q.size(), 2 * MB);
      end else begin
         for (int i = 0; i < 2 * MB; i++) begin
            n_cmp++;
            if (obs_mode_q[i] !== (i < MB)) begin
               n_bad++;
               $display("[TB] FAIL contention_order issue %0d: got mode %b want %b", i,
                        obs_mode_q[i], (i < MB));
            end
         end
      end
      drain_to_idle();
   endtask

   task automatic test_outstanding_limit();
      apply_reset();
      lat = 20;
      for (int i = 0; i < 21; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_issues !== MO) begin
         n_bad++;
         $display("[TB] FAIL limit_hold: issues got %0d want %0d", obs_issues, MO);
      end
      for (int i = 0; i < 2; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (obs_issues !== MO + 1) begin
         n_bad++;
         $display("[TB] FAIL limit_resume: issues got %0d want %0d", obs_issues, MO + 1);
      end
      drain_to_idle();
   endtask

   task automatic test_spurious_strobe();
      apply_reset();
      step_cycle(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (err_underflow !== 1'b1) begin
         n_bad++;
         $display("[TB] FAIL spurious_sticky: got %b want 1", err_underflow);
      end
      apply_reset();
      #1;
      n_cmp++;
      if (err_underflow !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL spurious_cleared: got %b want 0", err_underflow);
      end
   endtask

   task automatic test_reset_in_drain();
      apply_reset();
      lat = 10;
      for (int i = 0; i < 4; i++) step_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      step_cycle(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, sched_if.alu_dot_product_mode, sched_if.dp_req_ready,
           sched_if.vm_req_ready, sched_if.alu_ready} !== 5'b00000) begin
         n_bad++;
         $display("[TB] FAIL drain_reset: got busy=%b mode=%b rdy=%b%b alu=%b want 0", busy,
                  sched_if.alu_dot_product_mode, sched_if.dp_req_ready,
                  sched_if.vm_req_ready, sched_if.alu_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({busy, sched_if.alu_dot_product_mode} !== 2'b00) begin
         n_bad++;
         $display("[TB] FAIL drain_reset_next: got busy=%b mode=%b want 00", busy,
                  sched_if.alu_dot_product_mode);
      end
      apply_reset();
      cyc = 0;
   endtask

   task automatic test_random();
      bit dpv, vmv;
      for (int r = 0; r < 4; r++) begin
         lat = $urandom_range(1, 12);
         dpv = 1'b0;
         vmv = 1'b0;
         for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) dpv = !dpv;
            if ($urandom_range(0, 3) == 0) vmv = !vmv;
            step_cycle(dpv, vmv, 1'b0, 1'b0);
         end
         drain_to_idle();
      end
   endtask

   // Scenario sequence
   initial begin
      cyc = 0;
      lat = 1;
      rst_n = 1'b1;
      drive_idle();
      reset_model();
      test_reset();
      test_single_requester();
      test_contention();
      test_outstanding_limit();
      test_spurious_strobe();
      test_reset_in_drain();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
